// File: rtl/fpaddsub_norm_arbiter.sv
// rtl/fpaddsub_norm_arbiter.sv - two-lane round-robin front end to a shared 2-stage FP post-add normalizer
module fpaddsub_norm_arbiter #(
  parameter int MW = 26,
  parameter int EW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          R0_VALID,
  output logic          R0_READY,
  input  logic [MW-1:0] R0_SIG,
  input  logic [EW-1:0] R0_EXP,
  input  logic          R1_VALID,
  output logic          R1_READY,
  input  logic [MW-1:0] R1_SIG,
  input  logic [EW-1:0] R1_EXP,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic          O_LANE,
  output logic [MW-1:0] O_SIG,
  output logic [EW-1:0] O_EXP,
  output logic          O_ZERO,
  output logic          O_UFLOW
);

  // Count must hold 0..MW inclusive; the exponent path assumes EW >= CW.
  localparam int CW = $clog2(MW + 1);

  // Round-robin state: 1 means lane 1 was granted last, so lane 0 wins a tie.
  logic          rr_last_q;

  // Stage 1: captured request plus its leading-zero count.
  logic          s1_valid_q;
  logic          s1_lane_q;
  logic [MW-1:0] s1_sig_q;
  logic [EW-1:0] s1_exp_q;
  logic [CW-1:0] s1_cnt_q;

  // Stage 2: the output registers themselves.
  logic          o_valid_q;
  logic          o_lane_q;
  logic [MW-1:0] o_sig_q;
  logic [EW-1:0] o_exp_q;
  logic          o_zero_q;
  logic          o_uflow_q;

  // Handshake / arbitration intermediates.
  logic          s2_load;
  logic          s1_adv;
  logic          s1_load;
  logic          grant0;
  logic          grant1;
  logic          req_fire;
  logic          req_lane;
  logic [MW-1:0] sel_sig;
  logic [EW-1:0] sel_exp;
  logic [CW-1:0] lz_cnt;

  // Stage 2 next-state values derived from stage 1 contents.
  logic [MW-1:0] o_sig_d;
  logic [EW-1:0] o_exp_d;
  logic          o_zero_d;
  logic          o_uflow_d;
  logic [EW-1:0] cnt_ext;

  // Pipeline enables and the round-robin grant; READY only ever follows its own VALID.
  always_comb begin
    s2_load  = !o_valid_q || O_READY;
    s1_adv   = s1_valid_q && s2_load;
    s1_load  = !s1_valid_q || s1_adv;
    grant1   = R1_VALID && (!R0_VALID || !rr_last_q);
    grant0   = R0_VALID && !grant1;
    R0_READY = grant0 && s1_load;
    R1_READY = grant1 && s1_load;
    req_fire = R0_READY || R1_READY;
    req_lane = R1_READY;
    sel_sig  = R1_READY ? R1_SIG : R0_SIG;
    sel_exp  = R1_READY ? R1_EXP : R0_EXP;
  end

  // Leading-zero count of the granted significand, MSB first; all-zero yields MW.
  always_comb begin
    logic found;
    found  = 1'b0;
    lz_cnt = CW'(MW);
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && sel_sig[i]) begin
        lz_cnt = CW'(MW - 1 - i);
        found  = 1'b1;
      end
    end
  end

  // Stage 1 capture and round-robin pointer update on an actual request transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_lane_q  <= 1'b0;
      s1_sig_q   <= '0;
      s1_exp_q   <= '0;
      s1_cnt_q   <= '0;
      rr_last_q  <= 1'b1;
    end else begin
      if (s1_load) begin
        s1_valid_q <= req_fire;
      end
      if (req_fire) begin
        s1_lane_q <= req_lane;
        s1_sig_q  <= sel_sig;
        s1_exp_q  <= sel_exp;
        s1_cnt_q  <= lz_cnt;
        rr_last_q <= req_lane;
      end
    end
  end

  // Normalize: shift out leading zeros, or stop at exponent zero and flag underflow.
  always_comb begin
    cnt_ext   = EW'(s1_cnt_q);
    o_sig_d   = '0;
    o_exp_d   = '0;
    o_zero_d  = 1'b0;
    o_uflow_d = 1'b0;
    if (s1_sig_q == '0) begin
      o_zero_d = 1'b1;
    end else if ((s1_cnt_q != '0) && (cnt_ext >= s1_exp_q)) begin
      o_sig_d   = s1_sig_q << s1_exp_q;
      o_uflow_d = 1'b1;
    end else begin
      o_sig_d = s1_sig_q << s1_cnt_q;
      o_exp_d = s1_exp_q - cnt_ext;
    end
  end

  // Stage 2 output registers; hold everything while the consumer stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_valid_q <= 1'b0;
      o_lane_q  <= 1'b0;
      o_sig_q   <= '0;
      o_exp_q   <= '0;
      o_zero_q  <= 1'b0;
      o_uflow_q <= 1'b0;
    end else if (s2_load) begin
      o_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        o_lane_q  <= s1_lane_q;
        o_sig_q   <= o_sig_d;
        o_exp_q   <= o_exp_d;
        o_zero_q  <= o_zero_d;
        o_uflow_q <= o_uflow_d;
      end
    end
  end

  assign O_VALID = o_valid_q;
  assign O_LANE  = o_lane_q;
  assign O_SIG   = o_sig_q;
  assign O_EXP   = o_exp_q;
  assign O_ZERO  = o_zero_q;
  assign O_UFLOW = o_uflow_q;

endmodule

// File: tb/tb_fpaddsub_norm_arbiter.sv
// tb/tb_fpaddsub_norm_arbiter.sv - directed self-checking bench for fpaddsub_norm_arbiter
module tb_fpaddsub_norm_arbiter;

  logic        CLK;
  logic        RST;
  logic        R0_VALID, R0_READY, R1_VALID, R1_READY;
  logic [25:0] R0_SIG, R1_SIG, O_SIG;
  logic [7:0]  R0_EXP, R1_EXP, O_EXP;
  logic        O_VALID, O_READY, O_LANE, O_ZERO, O_UFLOW;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_lane[$];
  logic [31:0] q_sig[$];
  logic [31:0] q_exp[$];

  fpaddsub_norm_arbiter #(.MW(26), .EW(8)) dut (
    .CLK(CLK), .RST(RST),
    .R0_VALID(R0_VALID), .R0_READY(R0_READY), .R0_SIG(R0_SIG), .R0_EXP(R0_EXP),
    .R1_VALID(R1_VALID), .R1_READY(R1_READY), .R1_SIG(R1_SIG), .R1_EXP(R1_EXP),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_LANE(O_LANE), .O_SIG(O_SIG),
    .O_EXP(O_EXP), .O_ZERO(O_ZERO), .O_UFLOW(O_UFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic v0, input logic [25:0] s0, input logic [7:0] e0,
                       input logic v1, input logic [25:0] s1, input logic [7:0] e1);
    R0_VALID = v0; R0_SIG = s0; R0_EXP = e0;
    R1_VALID = v1; R1_SIG = s1; R1_EXP = e1;
  endtask

  // One request on one lane, then check the result two edges later.
  task automatic single(input string tag, input logic lane, input logic [25:0] sig,
                        input logic [7:0] ex, input logic [25:0] w_sig, input logic [7:0] w_exp,
                        input logic w_zero, input logic w_uf);
    if (lane) drive(1'b0, 26'h0, 8'h0, 1'b1, sig, ex);
    else      drive(1'b1, sig, ex, 1'b0, 26'h0, 8'h0);
    #1;
    check({tag, "_ready"}, {31'd0, lane ? R1_READY : R0_READY}, 32'd1);
    @(negedge CLK);
    drive(1'b0, 26'h0, 8'h0, 1'b0, 26'h0, 8'h0);
    check({tag, "_lat"}, {31'd0, O_VALID}, 32'd0);
    @(negedge CLK);
    check({tag, "_valid"}, {31'd0, O_VALID}, 32'd1);
    check({tag, "_lane"},  {31'd0, O_LANE},  {31'd0, lane});
    check({tag, "_sig"},   {6'd0, O_SIG},    {6'd0, w_sig});
    check({tag, "_exp"},   {24'd0, O_EXP},   {24'd0, w_exp});
    check({tag, "_zero"},  {31'd0, O_ZERO},  {31'd0, w_zero});
    check({tag, "_uflow"}, {31'd0, O_UFLOW}, {31'd0, w_uf});
    @(negedge CLK);
  endtask

  initial begin
    int n0, n1;
    logic [31:0] wl, ws, we;
    RST = 1'b1;
    O_READY = 1'b1;
    drive(1'b0, 26'h0, 8'h0, 1'b0, 26'h0, 8'h0);
    #2;
    check("rst_valid", {31'd0, O_VALID}, 32'd0);
    check("rst_outs", {6'd0, O_SIG} | {24'd0, O_EXP} | {31'd0, O_ZERO | O_UFLOW | O_LANE}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    single("t1",    1'b0, 26'h2000000, 8'd10,  26'h2000000, 8'd10, 1'b0, 1'b0);
    single("t2",    1'b1, 26'h0000001, 8'd100, 26'h2000000, 8'd75, 1'b0, 1'b0);
    single("t2z",   1'b1, 26'h0000000, 8'd50,  26'h0000000, 8'd0,  1'b1, 1'b0);
    single("t3a",   1'b1, 26'h0000100, 8'd5,   26'h0002000, 8'd0,  1'b0, 1'b1);
    single("t3b",   1'b1, 26'h0000100, 8'd17,  26'h2000000, 8'd0,  1'b0, 1'b1);
    single("t3c",   1'b1, 26'h0000100, 8'd18,  26'h2000000, 8'd1,  1'b0, 1'b0);
    single("t3d",   1'b1, 26'h0400000, 8'd0,   26'h0400000, 8'd0,  1'b0, 1'b1);

    // Fairness: both lanes valid for 6 cycles, last grant was lane 1.
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) drive(1'b1, 26'h2000000, 8'(n0 + 1), 1'b1, 26'h1000000, 8'(n1 + 20));
      else       drive(1'b0, 26'h0, 8'h0, 1'b0, 26'h0, 8'h0);
      #1;
      if (c < 6) begin
        check("rr_r0", {31'd0, R0_READY}, {31'd0, (c % 2) == 0});
        check("rr_r1", {31'd0, R1_READY}, {31'd0, (c % 2) == 1});
        q_lane.push_back(32'(c % 2));
        q_sig.push_back(32'h2000000);
        if ((c % 2) == 0) begin q_exp.push_back(32'(n0 + 1));  n0++; end
        else              begin q_exp.push_back(32'(n1 + 19)); n1++; end
      end
      if (c >= 2) begin
        wl = q_lane.pop_front(); ws = q_sig.pop_front(); we = q_exp.pop_front();
        check("rr_ovalid", {31'd0, O_VALID}, 32'd1);
        check("rr_olane",  {31'd0, O_LANE},  wl);
        check("rr_osig",   {6'd0, O_SIG},    ws);
        check("rr_oexp",   {24'd0, O_EXP},   we);
      end
      @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
    check("rr_drained", {31'd0, O_VALID}, 32'd0);

    // Backpressure: stall the consumer, only two entries may enter.
    O_READY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive(1'b1, 26'h0400000, 8'd40, 1'b1, 26'h0000003, 8'd30);
      else       drive(1'b1, 26'h3FFFFFF, 8'd99, 1'b1, 26'h0000001, 8'd1);
      #1;
      check("bp_r0", {31'd0, R0_READY}, {31'd0, c == 0});
      check("bp_r1", {31'd0, R1_READY}, {31'd0, c == 1});
      if (c >= 2) begin
        check("bp_hold_v", {31'd0, O_VALID}, 32'd1);
        check("bp_hold_l", {31'd0, O_LANE},  32'd0);
        check("bp_hold_s", {6'd0, O_SIG},    32'h2000000);
        check("bp_hold_e", {24'd0, O_EXP},   32'd37);
      end
      @(negedge CLK);
    end
    drive(1'b0, 26'h0, 8'h0, 1'b0, 26'h0, 8'h0);
    O_READY = 1'b1;
    #1;
    check("bp_out0_l", {31'd0, O_LANE}, 32'd0);
    check("bp_out0_e", {24'd0, O_EXP},  32'd37);
    @(negedge CLK);
    check("bp_out1_v", {31'd0, O_VALID}, 32'd1);
    check("bp_out1_l", {31'd0, O_LANE},  32'd1);
    check("bp_out1_s", {6'd0, O_SIG},    32'h3000000);
    check("bp_out1_e", {24'd0, O_EXP},   32'd6);
    @(negedge CLK);
    check("bp_no_dup", {31'd0, O_VALID}, 32'd0);

    // Reset mid-stream with S1 and S2 full; last grant before reset is lane 0.
    O_READY = 1'b0;
    drive(1'b1, 26'h2000000, 8'd3, 1'b0, 26'h0, 8'h0);
    repeat (2) @(negedge CLK);
    check("mr_full", {31'd0, O_VALID}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check("mr_async", {31'd0, O_VALID}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    O_READY = 1'b1;
    drive(1'b1, 26'h2000000, 8'd7, 1'b1, 26'h2000000, 8'd9);
    #1;
    check("mr_r0", {31'd0, R0_READY}, 32'd1);
    check("mr_r1", {31'd0, R1_READY}, 32'd0);
    @(negedge CLK);
    drive(1'b0, 26'h0, 8'h0, 1'b0, 26'h0, 8'h0);
    @(negedge CLK);
    check("mr_out_l", {31'd0, O_LANE}, 32'd0);
    check("mr_out_e", {24'd0, O_EXP},  32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
